// File: rtl/relm_spi_master.sv
// relm_spi_master: byte-level SPI master (mode 3, MSB first) for the USB host
// controller link. Commands arrive on a processor push port. Each command is a
// tx byte with an optional hold, or a release-only command. Received bytes are
// returned on a processor pop port, together with overrun and a synchronised
// slave interrupt.
module relm_spi_master #(
    parameter int WD  = 32,
    parameter int DIV = 2
) (
    input  logic          clk,
    input  logic          rst_in,
    input  logic [WD:0]   push_d_in,
    output logic          push_retry_out,
    input  logic [WD:0]   pop_d_in,
    output logic [WD:0]   pop_q_out,
    output logic          spi_ss_out,
    output logic          spi_sck_out,
    output logic          spi_mosi_out,
    input  logic          spi_miso_in,
    input  logic          spi_int_in
);

    // Every phase (LEAD, LOW, HIGH, TRAIL, GAP) lasts DIV cycles.
    localparam logic [7:0] DIV_RELOAD = 8'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        LOW,
        HIGH,
        TRAIL,
        GAP
    } state_t;

    state_t      state;

    // One pending command slot in front of the shifter.
    logic        pending_valid;
    logic [9:0]  pending_cmd;

    // Active byte.
    logic [7:0]  shift_reg;
    logic        hold_cur;
    logic [2:0]  bit_cnt;
    logic [7:0]  div_cnt;

    // Receive side.
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        overrun;

    // Interrupt synchroniser.
    logic        int_meta;
    logic        int_sync;

    logic        push_acc;
    logic        pop_req;
    logic        load_cmd;
    logic        phase_end;
    logic        byte_done;

    // Upper word bits carry nothing for this block.
    logic        unused_bits;

    assign push_acc       = push_d_in[WD] & ~pending_valid;
    assign pop_req        = pop_d_in[WD];
    assign load_cmd       = (state == IDLE) & pending_valid;
    assign phase_end      = (div_cnt == 8'd0);
    assign byte_done      = (state == HIGH) & phase_end & (bit_cnt == 3'd7);
    assign push_retry_out = pending_valid;
    assign unused_bits    = ^{push_d_in[WD-1:10], pop_d_in[WD-1:0]};

    assign pop_q_out = {~rx_valid, {(WD-10){1'b0}}, overrun, int_sync, rx_byte};

    // Pending slot: filled by an accepted push, emptied when IDLE loads it.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            pending_valid <= 1'b0;
            pending_cmd   <= 10'd0;
        end else begin
            pending_valid <= push_acc | (pending_valid & ~load_cmd);
            if (push_acc) begin
                pending_cmd <= push_d_in[9:0];
            end
        end
    end

    // Transfer FSM with registered SS/SCK/MOSI.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state        <= IDLE;
            spi_ss_out   <= 1'b1;
            spi_sck_out  <= 1'b1;
            spi_mosi_out <= 1'b0;
            shift_reg    <= 8'd0;
            hold_cur     <= 1'b0;
            bit_cnt      <= 3'd0;
            div_cnt      <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending_valid) begin
                        shift_reg <= pending_cmd[7:0];
                        hold_cur  <= pending_cmd[8];
                        bit_cnt   <= 3'd0;
                        div_cnt   <= DIV_RELOAD;
                        if (pending_cmd[9]) begin
                            // Release-only wins over hold, and always runs TRAIL+GAP.
                            state <= TRAIL;
                        end else if (!spi_ss_out) begin
                            // SS still low from a held byte: no lead-in needed.
                            state        <= LOW;
                            spi_sck_out  <= 1'b0;
                            spi_mosi_out <= pending_cmd[7];
                        end else begin
                            spi_ss_out <= 1'b0;
                            state      <= LEAD;
                        end
                    end
                end
                LEAD: begin
                    if (phase_end) begin
                        state        <= LOW;
                        spi_sck_out  <= 1'b0;
                        spi_mosi_out <= shift_reg[7];
                        div_cnt      <= DIV_RELOAD;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        state       <= HIGH;
                        spi_sck_out <= 1'b1;
                        div_cnt     <= DIV_RELOAD;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        // MISO is taken on the last HIGH cycle, just before SCK falls.
                        shift_reg <= {shift_reg[6:0], spi_miso_in};
                        bit_cnt   <= bit_cnt + 3'd1;
                        div_cnt   <= DIV_RELOAD;
                        if (bit_cnt == 3'd7) begin
                            state <= hold_cur ? IDLE : TRAIL;
                        end else begin
                            state        <= LOW;
                            spi_sck_out  <= 1'b0;
                            spi_mosi_out <= shift_reg[6];
                        end
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                TRAIL: begin
                    if (phase_end) begin
                        spi_ss_out <= 1'b1;
                        state      <= GAP;
                        div_cnt    <= DIV_RELOAD;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                GAP: begin
                    if (phase_end) begin
                        state <= IDLE;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Receive register: a completing byte beats a same-cycle pop.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            rx_byte  <= 8'd0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else if (byte_done) begin
            rx_byte  <= {shift_reg[6:0], spi_miso_in};
            rx_valid <= 1'b1;
            overrun  <= ~pop_req & (rx_valid | overrun);
        end else if (pop_req) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

    // Two-flop synchroniser for the asynchronous slave interrupt.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            int_meta <= 1'b0;
            int_sync <= 1'b0;
        end else begin
            int_meta <= spi_int_in;
            int_sync <= int_meta;
        end
    end

endmodule
